// File: rtl/mux_lut_arbiter_if.sv
// Request/response bundle between gate-op producers and the shared LUT arbiter.
interface mux_lut_arbiter_if #(
    parameter int N_REQ = 4
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_ready;
    logic [4*N_REQ-1:0] req_tt;
    logic [N_REQ-1:0]   req_a;
    logic [N_REQ-1:0]   req_b;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [ID_W-1:0]    rsp_id;
    logic               rsp_out;

    modport master (
        output req_valid, req_tt, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_out
    );

    modport slave (
        input  req_valid, req_tt, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_out
    );
endinterface

// File: rtl/mux_lut_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux LUT evaluator among N_REQ requesters.
// Optional eval counter enabled by defining MUX_ARB_STATS_EN.
module mux_4_1 (
    input  logic [3:0] i_d,
    input  logic [1:0] i_sel,
    output logic       o_y
);
    assign o_y = i_d[i_sel];
endmodule

module mux_lut_arbiter #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    mux_lut_arbiter_if.slave bus
`ifdef MUX_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] eval_cnt
`endif
);
    localparam int ID_W = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

    state_t            r_state, w_state_nxt;
    logic [ID_W-1:0]   r_rr_ptr, r_grant, w_grant;
    logic              w_found;
    logic [N_REQ-1:0]  w_ready;
    logic [3:0]        r_tt;
    logic              r_a, r_b;
    logic              w_mux;
    logic              r_rsp_valid, r_rsp_out;
    logic [ID_W-1:0]   r_rsp_id;

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!w_found && bus.req_valid[(int'(r_rr_ptr) + i) % N_REQ]) begin
                w_found = 1'b1;
                w_grant = ID_W'((int'(r_rr_ptr) + i) % N_REQ);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = '0;
        case (r_state)
            IDLE: if (w_found && rst_n) begin
                w_ready[w_grant] = 1'b1;
                w_state_nxt      = EVAL;
            end
            EVAL: w_state_nxt = RESP;
            RESP: if (bus.rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    mux_4_1 u_mux (
        .i_d   (r_tt),
        .i_sel ({r_a, r_b}),
        .o_y   (w_mux)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_grant     <= '0;
            r_tt        <= '0;
            r_a         <= 1'b0;
            r_b         <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_out   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: if (w_found) begin
                    r_tt    <= bus.req_tt[{w_grant, 2'b00} +: 4];
                    r_a     <= bus.req_a[w_grant];
                    r_b     <= bus.req_b[w_grant];
                    r_grant <= w_grant;
                end
                EVAL: begin
                    r_rsp_out   <= w_mux;
                    r_rsp_id    <= r_grant;
                    r_rsp_valid <= 1'b1;
                end
                RESP: if (bus.rsp_ready) begin
                    r_rsp_valid <= 1'b0;
                    r_rr_ptr    <= (r_grant == ID_W'(N_REQ - 1)) ? '0 : r_grant + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef MUX_ARB_STATS_EN
    logic [CNT_W-1:0] r_eval_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_eval_cnt <= '0;
        else if (r_state == RESP && bus.rsp_ready && r_eval_cnt != '1)
            r_eval_cnt <= r_eval_cnt + 1'b1;
    end

    assign eval_cnt = r_eval_cnt;
`endif

    assign bus.req_ready = w_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_out   = r_rsp_out;
endmodule
